// File: rtl/db_prbschk_pkg.sv
// Shared definitions for the PRBS byte checker.
//   state_t      : checker FSM state encoding (also exported on the debug port)
//   DEF_*        : default PRBS-15 geometry (x^15 + x^14 + 1)
//   popcount8    : number of set bits in a byte (combinational)
package db_prbschk_pkg;

    typedef enum logic [1:0] {
        ST_LOSS  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SYNC  = 2'd3
    } state_t;

    localparam int DEF_LEN     = 15;
    localparam int DEF_HIGHEXP = 14;
    localparam int DEF_LOWEXP  = 13;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/db_prbschk_if.sv
// Byte stream / status bundle between a receiver front end and db_prbschk.
// Handshake: ivld qualifies idata for exactly the cycle it is high; there is
// no back-pressure, the checker accepts every byte presented with ivld=1.
// iclr is a single-cycle request independent of ivld.
//   ivld, idata[7:0], iclr        : driven by master
//   osync, oerr, oerrcnt[15:0]    : driven by slave (the checker)
//   ostate                        : checker FSM state, debug visibility
interface db_prbschk_if;
    import db_prbschk_pkg::*;

    logic        ivld;
    logic [7:0]  idata;
    logic        iclr;
    logic        osync;
    logic        oerr;
    logic [15:0] oerrcnt;
    state_t      ostate;

    modport master (output ivld, idata, iclr,
                    input  osync, oerr, oerrcnt, ostate);
    modport slave  (input  ivld, idata, iclr,
                    output osync, oerr, oerrcnt, ostate);
endinterface

// File: rtl/db_prbschk_prbscal.sv
// db_prbscal: advances a Fibonacci PRBS register by 8 steps in one cycle.
// Each step shifts left and inserts state[HIGHEXP]^state[LOWEXP] at bit 0,
// so the byte produced has its oldest (first generated) bit at bit 7.
//   i_state[LEN-1:0] : current register
//   o_state[LEN-1:0] : register after 8 steps
//   o_byte[7:0]      : the 8 bits generated, i.e. o_state[7:0]
module db_prbscal #(
    parameter int LEN     = 15,
    parameter int HIGHEXP = 14,
    parameter int LOWEXP  = 13
) (
    input  logic [LEN-1:0] i_state,
    output logic [LEN-1:0] o_state,
    output logic [7:0]     o_byte
);

    logic [LEN-1:0] w_step;

    always_comb begin
        w_step = i_state;
        for (int i = 0; i < 8; i++) begin
            w_step = {w_step[LEN-2:0], w_step[HIGHEXP] ^ w_step[LOWEXP]};
        end
        o_state = w_step;
    end

    assign o_byte = o_state[7:0];

endmodule

// File: rtl/db_prbschk.sv
// db_prbschk: byte-wide PRBS receiver checker.
// Acquires lock by seeding from two received bytes, confirms with SYNCN
// consecutive correct bytes, then free-runs its own generator (flywheel) and
// counts bit errors until LOSSN consecutive errored bytes drop lock.
//   clk, rst  : clock, synchronous active-high reset
//   bus.ivld / bus.idata / bus.iclr   : byte stream in, error counter clear
//   bus.osync : high while locked (registered)
//   bus.oerr  : one-cycle pulse per mismatched byte in CHECK or SYNC
//   bus.oerrcnt : saturating bit-error count accumulated while locked
//   bus.ostate  : current FSM state
module db_prbschk
    import db_prbschk_pkg::*;
#(
    parameter int LEN     = DEF_LEN,
    parameter int HIGHEXP = DEF_HIGHEXP,
    parameter int LOWEXP  = DEF_LOWEXP,
    parameter int SYNCN   = 8,
    parameter int LOSSN   = 4
) (
    input  logic         clk,
    input  logic         rst,
    db_prbschk_if.slave  bus
);

    state_t         r_state, w_state_nxt;
    logic [LEN-1:0] r_prbs, w_prbs_nxt;
    logic [7:0]     r_seed, w_seed_nxt;
    logic [3:0]     r_good, w_good_nxt;
    logic [3:0]     r_bad, w_bad_nxt;
    logic           r_osync;
    logic           r_oerr, w_err_nxt;
    logic [15:0]    r_errcnt;

    logic [LEN-1:0] w_adv_prbs;
    logic [7:0]     w_exp_byte;
    logic [7:0]     w_diff;
    logic           w_mism;
    logic [3:0]     w_pop;
    logic [LEN-1:0] w_seed_state;
    logic           w_sync_byte;
    logic [16:0]    w_sum;

    db_prbscal #(
        .LEN     (LEN),
        .HIGHEXP (HIGHEXP),
        .LOWEXP  (LOWEXP)
    ) u_cal (
        .i_state (r_prbs),
        .o_state (w_adv_prbs),
        .o_byte  (w_exp_byte)
    );

    assign w_diff = bus.idata ^ w_exp_byte;
    assign w_mism = |w_diff;
    assign w_pop  = popcount8(w_diff);
    // Seed-high supplies the upper bits; the top (16-LEN) bits are discarded.
    assign w_seed_state = LEN'({r_seed, bus.idata});

    always_comb begin
        w_state_nxt = r_state;
        w_prbs_nxt  = r_prbs;
        w_seed_nxt  = r_seed;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_sync_byte = 1'b0;
        if (bus.ivld) begin
            case (r_state)
                ST_LOSS: begin
                    w_seed_nxt  = bus.idata;
                    w_state_nxt = ST_SEED;
                end
                ST_SEED: begin
                    // An all-zero register would lock onto a stuck-zero line.
                    if (w_seed_state == '0) begin
                        w_state_nxt = ST_LOSS;
                    end else begin
                        w_prbs_nxt  = w_seed_state;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_mism) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_LOSS;
                    end else begin
                        w_prbs_nxt = w_adv_prbs;
                        w_good_nxt = r_good + 4'd1;
                        if (r_good == 4'(SYNCN - 1)) begin
                            w_bad_nxt   = '0;
                            w_state_nxt = ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    // Flywheel: the local generator advances regardless of errors.
                    w_prbs_nxt  = w_adv_prbs;
                    w_sync_byte = 1'b1;
                    if (w_mism) begin
                        w_err_nxt = 1'b1;
                        w_bad_nxt = r_bad + 4'd1;
                        if (r_bad == 4'(LOSSN - 1)) begin
                            w_state_nxt = ST_LOSS;
                        end
                    end else begin
                        w_bad_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOSS;
                end
            endcase
        end
    end

    assign w_sum = {1'b0, r_errcnt} + {13'd0, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LOSS;
            r_prbs   <= '0;
            r_seed   <= '0;
            r_good   <= '0;
            r_bad    <= '0;
            r_osync  <= 1'b0;
            r_oerr   <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prbs  <= w_prbs_nxt;
            r_seed  <= w_seed_nxt;
            r_good  <= w_good_nxt;
            r_bad   <= w_bad_nxt;
            r_osync <= (w_state_nxt == ST_SYNC);
            r_oerr  <= w_err_nxt;
            // A clear coinciding with a locked byte keeps that byte's errors.
            if (bus.iclr) begin
                r_errcnt <= w_sync_byte ? {12'd0, w_pop} : 16'd0;
            end else if (w_sync_byte) begin
                r_errcnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            end
        end
    end

    assign bus.osync   = r_osync;
    assign bus.oerr    = r_oerr;
    assign bus.oerrcnt = r_errcnt;
    assign bus.ostate  = r_state;

endmodule

// File: tb/tb_db_prbschk.sv
// Testbench for db_prbschk: a PRBS transmitter and receiver model held as bit
// sequences (b[n] = b[n-15] ^ b[n-14]), a scoreboard queue of expected
// {state, osync, oerr, oerrcnt} per clock, and a negedge monitor.
module tb_db_prbschk;
    import db_prbschk_pkg::*;

    localparam int W     = 20;
    localparam int LEN_M = DEF_LEN;
    localparam int SYNCM = 8;
    localparam int LOSSM = 4;
    localparam int TH    = LEN_M - 1 - DEF_HIGHEXP;
    localparam int TL    = LEN_M - 1 - DEF_LOWEXP;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    db_prbschk_if bus();

    db_prbschk #(
        .LEN(DEF_LEN), .HIGHEXP(DEF_HIGHEXP), .LOWEXP(DEF_LOWEXP),
        .SYNCN(SYNCM), .LOSSN(LOSSM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    string phase = "init";
    logic [W-1:0] exp_q[$];

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("sb_%s", phase),
                  {bus.ostate, bus.osync, bus.oerr, bus.oerrcnt}, e);
        end
    end

    // ---------------- reference model ----------------
    bit m_tx[$];
    bit m_rx[$];
    state_t m_state;
    logic [7:0] m_seed;
    int m_good, m_bad, m_cnt;
    bit m_osync, m_oerr;

    function automatic void tx_init(input logic [14:0] s);
        m_tx.delete();
        for (int i = 0; i < LEN_M; i++) m_tx.push_back(s[LEN_M-1-i]);
    endfunction

    function automatic logic [7:0] tx_next();
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = m_tx[j+TH] ^ m_tx[j+TL];
        for (int j = 0; j < 8; j++) begin
            m_tx.push_back(b[7-j]);
            void'(m_tx.pop_front());
        end
        return b;
    endfunction

    function automatic logic [7:0] rx_peek();
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = m_rx[j+TH] ^ m_rx[j+TL];
        return b;
    endfunction

    function automatic void rx_take(input logic [7:0] b);
        for (int j = 0; j < 8; j++) begin
            m_rx.push_back(b[7-j]);
            void'(m_rx.pop_front());
        end
    endfunction

    function automatic void model_reset();
        m_state = ST_LOSS; m_seed = 0; m_good = 0; m_bad = 0;
        m_cnt = 0; m_osync = 0; m_oerr = 0;
        m_rx.delete();
    endfunction

    function automatic void model_step(input bit vld, input logic [7:0] d, input bit clr);
        int pop;
        bit sb;
        logic [15:0] w;
        logic [7:0] e;
        pop = 0; sb = 0; m_oerr = 0;
        if (vld) begin
            case (m_state)
                ST_LOSS: begin m_seed = d; m_state = ST_SEED; end
                ST_SEED: begin
                    w = {m_seed, d};
                    if (w[LEN_M-1:0] == 0) m_state = ST_LOSS;
                    else begin
                        m_rx.delete();
                        for (int i = 0; i < LEN_M; i++) m_rx.push_back(w[LEN_M-1-i]);
                        m_good = 0; m_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    e = rx_peek();
                    if (e != d) begin m_oerr = 1; m_state = ST_LOSS; end
                    else begin
                        rx_take(e); m_good++;
                        if (m_good == SYNCM) begin m_state = ST_SYNC; m_bad = 0; end
                    end
                end
                default: begin
                    e = rx_peek(); rx_take(e); sb = 1;
                    pop = $countones(e ^ d);
                    if (pop != 0) begin
                        m_oerr = 1; m_bad++;
                        if (m_bad == LOSSM) m_state = ST_LOSS;
                    end else m_bad = 0;
                end
            endcase
        end
        if (clr) m_cnt = sb ? pop : 0;
        else if (sb) m_cnt = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
        m_osync = (m_state == ST_SYNC);
    endfunction

    function automatic logic [W-1:0] model_out();
        return {m_state, m_osync, m_oerr, 16'(m_cnt)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit vld, input logic [7:0] d, input bit clr);
        bus.ivld = vld; bus.idata = d; bus.iclr = clr;
        @(posedge clk);
        model_step(vld, d, clr);
        exp_q.push_back(model_out());
        #1;
        bus.ivld = 1'b0; bus.iclr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.ivld = 1'b0; bus.iclr = 1'b0; bus.idata = 8'h00;
        @(posedge clk);
        model_reset();
        exp_q.push_back(model_out());
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] mask, input bit clr);
        logic [7:0] b;
        b = tx_next();
        cyc(1'b1, b ^ mask, clr);
    endtask

    // DUT outputs are settled 1 time unit after the edge, when these run.
    function automatic void chk_sync(input string n, input bit exp);
        check(n, W'(bus.osync), W'(exp));
    endfunction
    function automatic void chk_cnt(input string n, input logic [15:0] exp);
        check(n, W'(bus.oerrcnt), W'(exp));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]   masks[60];
    logic [W-1:0] ref_out[60];
    logic [14:0]  rseed;

    initial begin
        bus.ivld = 0; bus.idata = 0; bus.iclr = 0;
        @(negedge clk);
        phase = "reset";
        do_reset();
        do_reset();
        chk_sync("reset_osync", 1'b0);
        chk_cnt("reset_cnt", 16'h0000);

        // Acquisition from the 0x7FFF seed.
        phase = "acquire";
        tx_init(15'h7FFF);
        for (int i = 1; i <= 20; i++) begin
            send(8'h00, 1'b0);
            if (i == 9)  chk_sync("acq_before10", 1'b0);
            if (i == 10) chk_sync("acq_at10", 1'b1);
        end
        chk_cnt("acq_cnt", 16'h0000);

        // Single errored byte with three flipped bits.
        phase = "flip3";
        send(8'h29, 1'b0);
        check("flip3_oerr", W'(bus.oerr), W'(1'b1));
        chk_cnt("flip3_cnt", 16'd3);
        chk_sync("flip3_sync", 1'b1);
        send(8'h00, 1'b0);
        check("flip3_oerr_once", W'(bus.oerr), W'(1'b0));

        // Clear alone, then four inverted bytes, then reacquisition.
        phase = "burst4";
        cyc(1'b0, 8'h5A, 1'b1);
        chk_cnt("clr_alone", 16'd0);
        for (int i = 1; i <= 4; i++) begin
            send(8'hFF, 1'b0);
            if (i == 3) chk_sync("burst_3", 1'b1);
        end
        chk_sync("burst_4", 1'b0);
        chk_cnt("burst_cnt", 16'd32);
        for (int i = 1; i <= 10; i++) begin
            send(8'h00, 1'b0);
            if (i == 9)  chk_sync("reacq_9", 1'b0);
            if (i == 10) chk_sync("reacq_10", 1'b1);
        end

        // All-zero seed must never lock.
        phase = "zero_seed";
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'h00, 1'b0);
            chk_sync("zero_sync", 1'b0);
        end

        // Random stream, gap-free, recording model outputs per byte.
        phase = "random_nogap";
        for (int i = 0; i < 60; i++) begin
            if (i < 12 || i >= 46 || $urandom_range(0, 5) != 0) masks[i] = 8'h00;
            else masks[i] = 8'(1 << $urandom_range(0, 7)) | 8'($urandom_range(0, 1) << 3);
        end
        rseed = 15'($urandom_range(1, 32767));
        do_reset();
        tx_init(rseed);
        for (int i = 0; i < 60; i++) begin
            send(masks[i], 1'b0);
            ref_out[i] = model_out();
        end

        // Same stream with random idle gaps: per-byte results must agree.
        phase = "random_gap";
        do_reset();
        tx_init(rseed);
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) cyc(1'b0, 8'($urandom), 1'b0);
            send(masks[i], 1'b0);
            check($sformatf("gap_byte%0d", i),
                  {bus.ostate, bus.osync, bus.oerr, bus.oerrcnt}, ref_out[i]);
        end
        chk_sync("gap_locked", 1'b1);
        do_reset();
        chk_sync("rst_mid_sync", 1'b0);

        // Drive the counter to 0xFFFE, then saturate, then clear with errors.
        phase = "saturate";
        tx_init(15'h7FFF);
        for (int i = 0; i < 10; i++) send(8'h00, 1'b0);
        for (int g = 0; g < 2730; g++) begin
            send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0);
            send(8'h00, 1'b0);
        end
        send(8'hFF, 1'b0);
        send(8'h3F, 1'b0);
        send(8'h00, 1'b0);
        chk_cnt("preload_fffe", 16'hFFFE);
        send(8'h1F, 1'b0);
        chk_cnt("saturate_ffff", 16'hFFFF);
        chk_sync("saturate_sync", 1'b1);
        send(8'h81, 1'b1);
        chk_cnt("clr_with_err", 16'd2);
        send(8'h00, 1'b0);
        chk_cnt("after_clr", 16'd2);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
